// File: rtl/median_filter_frame_ctrl_pkg.sv
// Shared types and constants for the median filter frame controller.
// Error-cause indices select bits of the geometry checker's error vector.
package median_filter_frame_ctrl_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } mf_frame_state_t;

  localparam int ERR_SHORT_LINE = 0;
  localparam int ERR_LONG_LINE  = 1;
  localparam int ERR_EARLY_SOF  = 2;
  localparam int ERR_W          = 3;

endpackage

// File: rtl/median_filter_frame_geom_chk.sv
// Frame geometry checker: tracks x/y position on accepted beats and flags
// short lines, long lines and start-of-frame markers arriving mid-frame.
// Counters saturate rather than wrap so a runaway line cannot alias back
// to a valid position.
module median_filter_frame_geom_chk #(
  parameter int FRAME_RES_X = 1920,
  parameter int FRAME_RES_Y = 1080
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hs_i,
  input  logic sof_i,
  input  logic eol_i,
  output logic frame_done_o,
  output logic frame_err_o
);
  import median_filter_frame_ctrl_pkg::*;

  localparam int XW = $clog2(FRAME_RES_X + 1);
  localparam int YW = $clog2(FRAME_RES_Y + 1);
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_RES_X - 1);
  localparam logic [XW-1:0] X_MAX  = '1;
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_RES_Y - 1);
  localparam logic [YW-1:0] Y_MAX  = '1;

  mf_frame_state_t state, state_nxt;
  logic [XW-1:0]   x_cnt, x_base, x_nxt;
  logic [YW-1:0]   y_cnt, y_base, y_nxt;
  logic [ERR_W-1:0] err_vec;
  logic            done_nxt;
  logic            track;

  // Next position and error causes for the beat currently offered.
  // A SOF always restarts the frame from position 0, whatever the state.
  always_comb begin
    x_base    = x_cnt;
    y_base    = y_cnt;
    x_nxt     = x_cnt;
    y_nxt     = y_cnt;
    state_nxt = state;
    done_nxt  = 1'b0;
    track     = 1'b0;
    err_vec   = '0;
    if (sof_i) begin
      x_base                 = '0;
      y_base                 = '0;
      track                  = 1'b1;
      err_vec[ERR_EARLY_SOF] = (state == IN_FRAME);
    end else if (state == IN_FRAME) begin
      track = 1'b1;
    end
    if (track) begin
      if (eol_i) begin
        err_vec[ERR_SHORT_LINE] = (x_base < X_LAST);
        err_vec[ERR_LONG_LINE]  = (x_base > X_LAST);
        x_nxt = '0;
        if (y_base == Y_LAST) begin
          y_nxt     = '0;
          state_nxt = WAIT_SOF;
          done_nxt  = 1'b1;
        end else begin
          y_nxt     = (y_base == Y_MAX) ? y_base : y_base + 1'b1;
          state_nxt = IN_FRAME;
        end
      end else begin
        err_vec[ERR_LONG_LINE] = (x_base == X_LAST);
        x_nxt     = (x_base == X_MAX) ? x_base : x_base + 1'b1;
        y_nxt     = y_base;
        state_nxt = IN_FRAME;
      end
    end
  end

  // FSM and counters advance only on accepted beats; pulses are registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= WAIT_SOF;
      x_cnt        <= '0;
      y_cnt        <= '0;
      frame_err_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_err_o  <= hs_i && (|err_vec);
      frame_done_o <= hs_i && done_nxt;
      if (hs_i) begin
        state <= state_nxt;
        x_cnt <= x_nxt;
        y_cnt <= y_nxt;
      end
    end
  end

endmodule

// File: rtl/median_filter_frame_ctrl.sv
// In-line frame controller ahead of the median filter datapath.
// Single-stage register slice; the requested filter enable is applied only
// when a SOF beat is loaded, so a frame is never partly filtered.
// Optional build macro MEDIAN_FILTER_FRAME_STAT_EN adds frame and error
// counters (frame_cnt_o, err_cnt_o).
module median_filter_frame_ctrl #(
  parameter int TDATA_WIDTH = 16,
  parameter int FRAME_RES_X = 1920,
  parameter int FRAME_RES_Y = 1080
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   video_i_tvalid,
  output logic                   video_i_tready,
  input  logic [TDATA_WIDTH-1:0] video_i_tdata,
  input  logic                   video_i_tuser,
  input  logic                   video_i_tlast,
  output logic                   video_o_tvalid,
  input  logic                   video_o_tready,
  output logic [TDATA_WIDTH-1:0] video_o_tdata,
  output logic                   video_o_tuser,
  output logic                   video_o_tlast,
  input  logic                   mf_ctrl_i_en,
  output logic                   mf_ctrl_o_en,
  output logic                   pending_o,
  output logic                   frame_err_o
`ifdef MEDIAN_FILTER_FRAME_STAT_EN
  ,
  output logic [31:0]            frame_cnt_o,
  output logic [15:0]            err_cnt_o
`endif
);
  import median_filter_frame_ctrl_pkg::*;

  logic out_valid;
  logic in_hs;
  logic en_app;
  logic frame_done_unused;

  assign video_i_tready = !out_valid || video_o_tready;
  assign in_hs          = video_i_tvalid && video_i_tready;
  assign video_o_tvalid = out_valid;
  assign mf_ctrl_o_en   = en_app;
  assign pending_o      = mf_ctrl_i_en ^ en_app;

  // Register slice plus enable capture on the edge that loads a SOF beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid     <= 1'b0;
      video_o_tdata <= '0;
      video_o_tuser <= 1'b0;
      video_o_tlast <= 1'b0;
      en_app        <= 1'b1;
    end else if (in_hs) begin
      out_valid     <= 1'b1;
      video_o_tdata <= video_i_tdata;
      video_o_tuser <= video_i_tuser;
      video_o_tlast <= video_i_tlast;
      if (video_i_tuser) begin
        en_app <= mf_ctrl_i_en;
      end
    end else if (video_o_tready) begin
      out_valid <= 1'b0;
    end
  end

  median_filter_frame_geom_chk #(
    .FRAME_RES_X(FRAME_RES_X),
    .FRAME_RES_Y(FRAME_RES_Y)
  ) u_geom_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .hs_i        (in_hs),
    .sof_i       (video_i_tuser),
    .eol_i       (video_i_tlast),
    .frame_done_o(frame_done_unused),
    .frame_err_o (frame_err_o)
  );

`ifdef MEDIAN_FILTER_FRAME_STAT_EN
  // Frame counter wraps; error counter sticks at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      if (in_hs && video_i_tuser) begin
        frame_cnt_o <= frame_cnt_o + 32'd1;
      end
      if (frame_err_o && (err_cnt_o != 16'hFFFF)) begin
        err_cnt_o <= err_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_median_filter_frame_ctrl.sv
// Directed bench for median_filter_frame_ctrl on a 4x2 frame geometry.
module tb_median_filter_frame_ctrl;

  logic        clk;
  logic        rst;
  logic        vi_tvalid;
  logic        vi_tready;
  logic [15:0] vi_tdata;
  logic        vi_tuser;
  logic        vi_tlast;
  logic        vo_tvalid;
  logic        vo_tready;
  logic [15:0] vo_tdata;
  logic        vo_tuser;
  logic        vo_tlast;
  logic        en_req;
  logic        en_o;
  logic        pending;
  logic        frame_err;
`ifdef MEDIAN_FILTER_FRAME_STAT_EN
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out;
  int   rx;
  int   idx;
  logic err_seen;
  logic in_take;

  median_filter_frame_ctrl #(
    .TDATA_WIDTH(16),
    .FRAME_RES_X(4),
    .FRAME_RES_Y(2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .video_i_tvalid(vi_tvalid),
    .video_i_tready(vi_tready),
    .video_i_tdata (vi_tdata),
    .video_i_tuser (vi_tuser),
    .video_i_tlast (vi_tlast),
    .video_o_tvalid(vo_tvalid),
    .video_o_tready(vo_tready),
    .video_o_tdata (vo_tdata),
    .video_o_tuser (vo_tuser),
    .video_o_tlast (vo_tlast),
    .mf_ctrl_i_en  (en_req),
    .mf_ctrl_o_en  (en_o),
    .pending_o     (pending),
    .frame_err_o   (frame_err)
`ifdef MEDIAN_FILTER_FRAME_STAT_EN
    ,
    .frame_cnt_o   (frame_cnt),
    .err_cnt_o     (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic s, input logic l);
    vi_tvalid = 1'b1;
    vi_tdata  = d;
    vi_tuser  = s;
    vi_tlast  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vi_tvalid = 1'b0;
    vi_tuser  = 1'b0;
    vi_tlast  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    vi_tvalid = 1'b0;
    vi_tdata  = '0;
    vi_tuser  = 1'b0;
    vi_tlast  = 1'b0;
    vo_tready = 1'b1;
    en_req    = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    chk("rst_tvalid", vo_tvalid, 0);
    chk("rst_tdata", vo_tdata, 0);
    chk("rst_tuser", vo_tuser, 0);
    chk("rst_tlast", vo_tlast, 0);
    chk("rst_en", en_o, 1);
    chk("rst_pend", pending, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_tready", vi_tready, 1);
    en_req = 1'b0;
    #1;
    chk("rst_pend_req0", pending, 1);
    en_req = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // mid-frame enable toggle over two 4x2 frames
    for (int i = 0; i < 16; i++) begin
      if (i == 3) en_req = 1'b0;
      beat(16'(16'h0100 + i), (i % 8) == 0, (i % 4) == 3);
      chk("t1_data", vo_tdata, 32'(16'h0100 + i));
      chk("t1_en", en_o, (i < 8) ? 1 : 0);
      chk("t1_pend", pending, (i >= 3 && i < 8) ? 1 : 0);
      chk("t1_err", frame_err, 0);
    end
    idle();
    chk("t1_drain", vo_tvalid, 0);

    // throughput: three back-to-back frames
    n_out    = 0;
    err_seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (c < 24) begin
        vi_tvalid = 1'b1;
        vi_tdata  = 16'(16'h0200 + c);
        vi_tuser  = (c % 8) == 0;
        vi_tlast  = (c % 4) == 3;
      end else begin
        vi_tvalid = 1'b0;
        vi_tuser  = 1'b0;
        vi_tlast  = 1'b0;
      end
      #1;
      if (vo_tvalid && vo_tready) begin
        chk("t2_data", vo_tdata, 32'(16'h0200 + n_out));
        n_out++;
      end
      err_seen = err_seen | frame_err;
      @(posedge clk);
      #1;
    end
    chk("t2_beats", n_out, 24);
    chk("t2_err", err_seen, 0);
    chk("t2_drain", vo_tvalid, 0);
    chk("t2_en", en_o, 0);

    // short line on line 0
    for (int i = 0; i < 7; i++) begin
      beat(16'(16'h0300 + i), i == 0, (i == 2) || (i == 6));
      chk("t3_data", vo_tdata, 32'(16'h0300 + i));
      chk("t3_err", frame_err, (i == 2) ? 1 : 0);
    end
    idle();
    chk("t3_err_idle", frame_err, 0);

    // early SOF at line 1 pixel 2 with enable re-capture
    for (int i = 0; i < 14; i++) begin
      if (i == 6) en_req = 1'b1;
      beat(16'(16'h0500 + i), (i == 0) || (i == 6), (i == 3) || (i == 9) || (i == 13));
      chk("t4_err", frame_err, (i == 6) ? 1 : 0);
      chk("t4_en", en_o, (i >= 6) ? 1 : 0);
      chk("t4_pend", pending, 0);
    end
    idle();

    // SOF stalled at the output, then random backpressure
    en_req = 1'b0;
    #1;
    chk("t5_pend_pre", pending, 1);
    vo_tready = 1'b0;
    beat(16'h0600, 1'b1, 1'b0);
    chk("t5_sof_valid", vo_tvalid, 1);
    chk("t5_sof_user", vo_tuser, 1);
    chk("t5_sof_data", vo_tdata, 16'h0600);
    chk("t5_sof_en", en_o, 0);
    chk("t5_sof_pend", pending, 0);
    vi_tvalid = 1'b1;
    vi_tdata  = 16'h0601;
    vi_tuser  = 1'b0;
    vi_tlast  = 1'b0;
    #1;
    chk("t5_stall_rdy", vi_tready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_hold_data", vo_tdata, 16'h0600);
    chk("t5_hold_valid", vo_tvalid, 1);
    chk("t5_hold_en", en_o, 0);
    idx      = 1;
    rx       = 0;
    err_seen = 1'b0;
    for (int c = 0; c < 200 && rx < 8; c++) begin
      vo_tready = 1'($urandom_range(0, 1));
      if (idx < 8) begin
        vi_tvalid = 1'b1;
        vi_tdata  = 16'(16'h0600 + idx);
        vi_tuser  = 1'b0;
        vi_tlast  = (idx == 3) || (idx == 7);
      end else begin
        vi_tvalid = 1'b0;
        vi_tlast  = 1'b0;
      end
      #1;
      in_take = vi_tvalid && vi_tready;
      if (vo_tvalid && vo_tready) begin
        chk("t5_data", vo_tdata, 32'(16'h0600 + rx));
        rx++;
      end
      err_seen = err_seen | frame_err;
      @(posedge clk);
      #1;
      if (in_take) idx++;
    end
    chk("t5_rx", rx, 8);
    chk("t5_tx", idx, 8);
    chk("t5_err", err_seen, 0);
    vo_tready = 1'b1;
    idle();
    chk("t5_drain", vo_tvalid, 0);

`ifdef MEDIAN_FILTER_FRAME_STAT_EN
    chk("stat_frames", frame_cnt, 9);
    chk("stat_errs", err_cnt, 2);
`endif

    // reset mid-frame, then beats without SOF
    beat(16'h0700, 1'b1, 1'b0);
    beat(16'h0701, 1'b0, 1'b0);
    chk("t6_pre_en", en_o, 0);
    rst = 1'b1;
    vi_tvalid = 1'b0;
    #1;
    chk("t6_rst_valid", vo_tvalid, 0);
    chk("t6_rst_data", vo_tdata, 0);
    chk("t6_rst_en", en_o, 1);
    chk("t6_rst_pend", pending, 1);
    chk("t6_rst_err", frame_err, 0);
`ifdef MEDIAN_FILTER_FRAME_STAT_EN
    chk("t6_rst_frames", frame_cnt, 0);
    chk("t6_rst_errs", err_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat(16'(16'h0710 + i), 1'b0, (i == 1) || (i == 4));
      chk("t6_data", vo_tdata, 32'(16'h0710 + i));
      chk("t6_en", en_o, 1);
      chk("t6_err", frame_err, 0);
    end
    idle();
    chk("t6_err_idle", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
